// File: rtl/compare_seq_if.sv
// Request/result bundle for the sequential wide comparator.
// master = requester side, slave = comparator side.
interface compare_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int NW    = $clog2(NIBBLES + 1);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [NW-1:0]    ncmp;

  modport master (
    output start, a, b,
    input  busy, done, gt, lt, eq, ncmp
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, lt, eq, ncmp
  );
endinterface

// File: rtl/compare_seq.sv
// Sequential unsigned magnitude comparator: one 4-bit slice is reused across
// the operand, MSB nibble first, stopping at the first unequal nibble.

module compare_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);
  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);
endmodule

module compare_seq #(
  parameter int NIBBLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  compare_seq_if.slave bus
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int NW    = $clog2(NIBBLES + 1);
  localparam int IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic [NW-1:0]    ncmp_q, ncmp_d;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic       s_gt;
  logic       s_lt;
  logic       s_eq;

  // Nibble mux feeding the shared slice; a single-nibble build needs no index.
  generate
    if (NIBBLES == 1) begin : g_single
      assign a_nib = a_q[3:0];
      assign b_nib = b_q[3:0];
    end else begin : g_multi
      logic [3:0] a_arr [NIBBLES];
      logic [3:0] b_arr [NIBBLES];
      for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign a_arr[gi] = a_q[4*gi +: 4];
        assign b_arr[gi] = b_q[4*gi +: 4];
      end
      assign a_nib = a_arr[idx_q];
      assign b_nib = b_arr[idx_q];
    end
  endgenerate

  compare_4 u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .gt (s_gt),
    .lt (s_lt),
    .eq (s_eq)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    ncmp_d  = ncmp_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = IW'(NIBBLES - 1);
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          ncmp_d  = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ncmp_d = ncmp_q + NW'(1);
        if (s_gt || s_lt) begin
          gt_d    = s_gt;
          lt_d    = s_lt;
          eq_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (idx_q == '0) begin
          // Every nibble matched down to the LSB.
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = s_eq;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      ncmp_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      ncmp_q  <= ncmp_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.gt   = gt_q;
  assign bus.lt   = lt_q;
  assign bus.eq   = eq_q;
  assign bus.ncmp = ncmp_q;

endmodule
